// File: rtl/instr_fetch_unit.sv
// Purpose : fetches the instruction word at PC from a multi-cycle instruction
//           memory (req/ack) and presents it to decode (valid/taken).
// Latency : imem_req rises 1 cycle after fetch_en; instr_valid rises 1 cycle
//           after imem_ack.
// Backpressure: a fetched word is held in HOLD until decode takes it; no new
//           fetch starts until then, and there is one bubble cycle between fetches.
// Ports   : CLK/RST (sync, active-high); PC, fetch_en, redirect from the core;
//           imem_req/imem_addr/imem_ack/imem_rdata to memory; instr/instr_valid/
//           instr_taken to decode; busy, misaligned, bus_err status.
module instr_fetch_unit #(
  parameter int WL      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [WL-1:0] PC,
  input  logic          fetch_en,
  input  logic          redirect,
  output logic          imem_req,
  output logic [WL-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [WL-1:0] imem_rdata,
  output logic [WL-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_taken,
  output logic          busy,
  output logic          misaligned,
  output logic          bus_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t        state_q;
  logic          req_q;
  logic [WL-1:0] addr_q;
  logic [WL-1:0] instr_q;
  logic          valid_q;
  logic          mis_q;
  logic          berr_q;
  logic          drop_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Wait counter saturates so a very long stall can never wrap it back
  // below the timeout threshold.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_en && (PC[1:0] != 2'b00)) begin
            mis_q   <= 1'b1;
            state_q <= FAULT;
          end else if (fetch_en && !redirect) begin
            addr_q  <= PC;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            state_q <= REQ;
          end
        end

        REQ: begin
          // The request stays up until ack or timeout; a redirect only
          // marks the returning word for discard.
          if (imem_ack) begin
            req_q  <= 1'b0;
            drop_q <= 1'b0;
            if (drop_q || redirect) begin
              state_q <= IDLE;
            end else begin
              instr_q <= imem_rdata;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end
          end else if (cnt_q == CNT_LAST) begin
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
            berr_q  <= 1'b1;
            state_q <= FAULT;
          end else begin
            cnt_q <= cnt_d;
            if (redirect) begin
              drop_q <= 1'b1;
            end
          end
        end

        HOLD: begin
          // instr keeps its value after valid drops; only valid is cleared.
          if (instr_taken || redirect) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end

        FAULT: begin
          if (redirect) begin
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign busy        = (state_q == REQ);
  assign misaligned  = mis_q;
  assign bus_err     = berr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose : directed bench for instr_fetch_unit; stimulus pushes expected
//           request addresses and instruction words into queues, a monitor
//           pops and compares whenever the DUT raises imem_req / instr_valid.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PC;
  logic        fetch_en;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_taken;
  logic        busy;
  logic        misaligned;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.WL(32), .TIMEOUT(16)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .PC          (PC),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_taken (instr_taken),
    .busy        (busy),
    .misaligned  (misaligned),
    .bus_err     (bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic        prev_req   = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] held_addr  = '0;
  logic [31:0] held_instr = '0;

  always @(negedge CLK) begin
    if (imem_req && !prev_req) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: imem_req=1 addr=0x%08h with no fetch expected", imem_addr);
      end else begin
        chk("req_addr", imem_addr, exp_addr_q.pop_front());
      end
      held_addr = imem_addr;
    end else if (imem_req) begin
      chk("req_addr_stable", imem_addr, held_addr);
    end

    if (instr_valid && !prev_valid) begin
      if (exp_instr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr_valid: instr_valid=1 instr=0x%08h with none expected", instr);
      end else begin
        chk("instr_word", instr, exp_instr_q.pop_front());
      end
      held_instr = instr;
    end else if (instr_valid) begin
      chk("instr_hold_stable", instr, held_instr);
    end

    prev_req   = imem_req;
    prev_valid = instr_valid;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
    chk({tag, "_addr"},  imem_addr,            32'd0);
    chk({tag, "_instr"}, instr,                32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy},        32'd0);
    chk({tag, "_mis"},   {31'd0, misaligned},  32'd0);
    chk({tag, "_berr"},  {31'd0, bus_err},     32'd0);
  endtask

  // Issue an aligned fetch; returns in the first REQ cycle.
  task automatic start_fetch(input logic [31:0] addr);
    PC       = addr;
    fetch_en = 1'b1;
    exp_addr_q.push_back(addr);
    tick();
    fetch_en = 1'b0;
  endtask

  initial begin
    int n;
    RST = 1'b1; PC = '0; fetch_en = 1'b0; redirect = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; instr_taken = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    chk_all_zero("reset");

    // Basic fetch: ack 3 cycles after imem_req first seen high.
    start_fetch(32'h0000_0040);
    chk("basic_busy", {31'd0, busy}, 32'd1);
    tick(); tick(); tick();
    imem_ack = 1'b1; imem_rdata = 32'h2010_0005;
    exp_instr_q.push_back(32'h2010_0005);
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    chk("basic_valid_after_ack", {31'd0, instr_valid}, 32'd1);
    chk("basic_req_dropped", {31'd0, imem_req}, 32'd0);
    tick(); tick();
    // fetch_en together with taken must not start a fetch (bubble)
    instr_taken = 1'b1; fetch_en = 1'b1; PC = 32'h0000_0044;
    tick();
    instr_taken = 1'b0; fetch_en = 1'b0;
    chk("basic_valid_fall", {31'd0, instr_valid}, 32'd0);
    chk("basic_instr_kept", instr, 32'h2010_0005);
    tick();
    chk("basic_bubble_no_req", {31'd0, imem_req}, 32'd0);
    chk("basic_idle_busy", {31'd0, busy}, 32'd0);

    // Redirect in flight: word discarded, request not withdrawn.
    start_fetch(32'h0000_0100);
    tick();
    redirect = 1'b1; PC = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    chk("redir_req_held", {31'd0, imem_req}, 32'd1);
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("redir_no_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_req_low", {31'd0, imem_req}, 32'd0);
    start_fetch(32'h0000_0200);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    exp_instr_q.push_back(32'hDEAD_BEEF);
    tick();
    imem_ack = 1'b0;
    chk("redir_refetch_valid", {31'd0, instr_valid}, 32'd1);
    instr_taken = 1'b1;
    tick();
    instr_taken = 1'b0;

    // Misaligned PC.
    PC = 32'h0000_0042; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("mis_flag", {31'd0, misaligned}, 32'd1);
    chk("mis_no_req", {31'd0, imem_req}, 32'd0);
    PC = 32'h0000_0044; fetch_en = 1'b1;
    tick(); tick();
    fetch_en = 1'b0;
    chk("mis_held", {31'd0, misaligned}, 32'd1);
    chk("mis_fetch_ignored", {31'd0, imem_req}, 32'd0);
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    chk("mis_cleared", {31'd0, misaligned}, 32'd0);

    // Timeout: imem_req must be high exactly 16 cycles.
    start_fetch(32'h0000_0080);
    n = 0;
    while (imem_req && n < 40) begin
      n++;
      tick();
    end
    chk("timeout_req_cycles", n, 32'd16);
    chk("timeout_bus_err", {31'd0, bus_err}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_ack = 1'b0;
    chk("timeout_late_ack_ignored", {31'd0, instr_valid}, 32'd0);
    chk("timeout_berr_held", {31'd0, bus_err}, 32'd1);
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    chk("timeout_berr_cleared", {31'd0, bus_err}, 32'd0);

    // Reset during REQ with an ack in the reset cycle.
    start_fetch(32'h0000_0300);
    tick();
    RST = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_1234;
    tick();
    RST = 1'b0; imem_ack = 1'b0;
    chk_all_zero("rst_req");
    tick();
    chk("rst_req_no_valid_later", {31'd0, instr_valid}, 32'd0);

    // Reset during HOLD.
    start_fetch(32'h0000_0400);
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001;
    exp_instr_q.push_back(32'hCAFE_0001);
    tick();
    imem_ack = 1'b0;
    chk("rst_hold_valid_before", {31'd0, instr_valid}, 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_all_zero("rst_hold");

    // Hold stability while inputs toggle.
    start_fetch(32'h0000_0500);
    imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D;
    exp_instr_q.push_back(32'h0BAD_F00D);
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      PC = 32'h0000_1000 + 32'(i * 4);
      imem_rdata = ~imem_rdata;
      imem_ack = i[0];
      tick();
      chk("hold_instr", instr, 32'h0BAD_F00D);
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    end
    imem_ack = 1'b0;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    chk("hold_redirect_valid_fall", {31'd0, instr_valid}, 32'd0);

    // Ack on the timeout cycle (16th REQ cycle) wins over bus_err.
    start_fetch(32'h0000_0600);
    for (int i = 0; i < 15; i++) tick();
    imem_ack = 1'b1; imem_rdata = 32'h600D_0001;
    exp_instr_q.push_back(32'h600D_0001);
    tick();
    imem_ack = 1'b0;
    chk("edge_ack_valid", {31'd0, instr_valid}, 32'd1);
    chk("edge_ack_no_berr", {31'd0, bus_err}, 32'd0);
    instr_taken = 1'b1;
    tick();
    instr_taken = 1'b0;
    tick(); tick();

    chk("addr_queue_drained", exp_addr_q.size(), 32'd0);
    chk("instr_queue_drained", exp_instr_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
